// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the sequential one-hot decoder: index-width helper
// and the command state encoding.
package onehot_decoder_seq_pkg;

  // Ceiling log2, floored at 1 so a 2-output decoder still has a 1-bit index.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_decoder_seq_decode.sv
// Combinational binary-to-one-hot decode with range check against N
// (not 2**IW), so out-of-range indices produce an all-zero vector plus err.
module onehot_decode_comb #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [IW-1:0] idx_i,
  output logic [N-1:0]  onehot_o,
  output logic          err_o
);

  assign err_o = ({1'b0, idx_i} >= (IW+1)'(N));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign onehot_o[gi] = (idx_i == IW'(gi)) & ~err_o;
    end
  endgenerate

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder with valid/ready on both sides and an
// optional scan mode that walks the select from a start index up to N-1.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = log2c(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] in_idx,
  input  logic          in_none,
  input  logic          in_scan,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_onehot,
  output logic          out_none,
  output logic          out_err,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cursor_q, cursor_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic          none_q, none_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  logic          in_fire, out_fire;
  logic [N-1:0]  load_onehot, step_onehot;
  logic          load_err, step_err;
  logic [IW-1:0] step_idx;

  // cursor never passes N-1 while a non-last beat is pending, so +1 cannot wrap
  assign step_idx = cursor_q + 1'b1;

  onehot_decode_comb #(.N(N), .IW(IW)) u_load_dec (
    .idx_i    (in_idx),
    .onehot_o (load_onehot),
    .err_o    (load_err)
  );

  onehot_decode_comb #(.N(N), .IW(IW)) u_step_dec (
    .idx_i    (step_idx),
    .onehot_o (step_onehot),
    .err_o    (step_err)
  );

  // Reload in the same cycle the final beat leaves keeps single mode at full rate.
  assign in_ready = (state_q == ST_IDLE) | (valid_q & out_ready & last_q);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    onehot_d = onehot_q;
    none_d   = none_q;
    err_d    = err_q;
    last_d   = last_q;
    valid_d  = valid_q;

    if ((state_q == ST_SCAN) && out_fire && !last_q) begin
      cursor_d = step_idx;
      onehot_d = step_onehot;
      err_d    = step_err;
      last_d   = (step_idx == LAST_IDX);
    end else if (in_fire) begin
      valid_d  = 1'b1;
      none_d   = in_none;
      cursor_d = in_idx;
      if (in_none || load_err) begin
        state_d  = ST_SINGLE;
        onehot_d = '0;
        err_d    = load_err & ~in_none;
        last_d   = 1'b1;
      end else if (!in_scan) begin
        state_d  = ST_SINGLE;
        onehot_d = load_onehot;
        err_d    = 1'b0;
        last_d   = 1'b1;
      end else begin
        state_d  = ST_SCAN;
        onehot_d = load_onehot;
        err_d    = 1'b0;
        last_d   = (in_idx == LAST_IDX);
      end
    end else if (out_fire) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cursor_q <= '0;
      onehot_q <= '0;
      none_q   <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      onehot_q <= onehot_d;
      none_q   <= none_d;
      err_q    <= err_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_none   = none_q;
  assign out_err    = err_q;
  assign out_last   = last_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: directed steps plus randomized commands against a
// beat-list reference model, on N=8 and N=6 instances.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [2:0] in_idx;
  logic       in_none, in_scan, in_valid, in_ready;
  logic [7:0] out_onehot;
  logic       out_none, out_err, out_last, out_valid, out_ready;

  logic [2:0] idx6;
  logic       none6, scan6, valid6, ready6;
  logic [5:0] oh6;
  logic       onone6, oerr6, olast6, ovalid6, oready6;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] oh;
    bit         none;
    bit         err;
    bit         last;
    int         idx;
  } beat_t;
  beat_t exp_q[$];

  onehot_decoder_seq #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_idx(in_idx), .in_none(in_none), .in_scan(in_scan),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_onehot(out_onehot), .out_none(out_none), .out_err(out_err),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  onehot_decoder_seq #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_idx(idx6), .in_none(none6), .in_scan(scan6),
    .in_valid(valid6), .in_ready(ready6),
    .out_onehot(oh6), .out_none(onone6), .out_err(oerr6),
    .out_last(olast6), .out_valid(ovalid6), .out_ready(oready6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a command expands into the list of beats it must produce.
  task automatic model_cmd(input int idx, input bit none, input bit scan);
    beat_t b;
    if (none || idx >= 8) begin
      b.oh = 8'h00; b.none = none; b.err = (idx >= 8) && !none; b.last = 1'b1; b.idx = -1;
      exp_q.push_back(b);
    end else if (!scan) begin
      b.oh = 8'(1 << idx); b.none = 1'b0; b.err = 1'b0; b.last = 1'b1; b.idx = idx;
      exp_q.push_back(b);
    end else begin
      for (int k = idx; k < 8; k++) begin
        b.oh = 8'(1 << k); b.none = 1'b0; b.err = 1'b0; b.last = (k == 7); b.idx = k;
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic int enc(input logic [7:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Output monitor: every beat that transfers is compared with the model.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid) begin
      check("inv_popcount_le1", 32'($countones(out_onehot) <= 1), 32'd1);
      check("inv_zero_iff_flag", 32'($countones(out_onehot) == 0), 32'(out_none | out_err));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat_onehot", 32'(out_onehot), 32'(e.oh));
          check("beat_none", 32'(out_none), 32'(e.none));
          check("beat_err", 32'(out_err), 32'(e.err));
          check("beat_last", 32'(out_last), 32'(e.last));
          if (e.idx >= 0) check("encoder_roundtrip", 32'(enc(out_onehot)), 32'(e.idx));
        end
      end
    end
  end

  task automatic issue(input int idx, input bit none, input bit scan, input bit rand_bp, output int waits);
    int w;
    in_idx = 3'(idx); in_none = none; in_scan = scan; in_valid = 1'b1;
    for (w = 0; w < 200; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    waits = w;
    if (w >= 200) check("accept_timeout", 32'(w), 32'd0);
    else model_cmd(idx, none, scan);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input bit rand_bp);
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
      out_ready = (rand_bp && i < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("drain_idle_valid", 32'(out_valid), 32'd0);
    check("drain_idle_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic issue6(input int idx, input bit none, input bit scan);
    idx6 = 3'(idx); none6 = none; scan6 = scan; valid6 = 1'b1;
    @(negedge clk);
    check("n6_ready", 32'(ready6), 32'd1);
    @(posedge clk); #1;
    valid6 = 1'b0;
  endtask

  initial begin
    int w;
    in_idx = '0; in_none = 0; in_scan = 0; in_valid = 0; out_ready = 1;
    idx6 = '0; none6 = 0; scan6 = 0; valid6 = 0; oready6 = 1;

    // Reset values appear asynchronously.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_none_err", 32'({out_none, out_err}), 32'd0);
    check("rst6_valid", 32'(ovalid6), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single decode with one-cycle latency.
    issue(5, 0, 0, 0, w);
    check("s5_wait", 32'(w), 32'd0);
    check("s5_valid", 32'(out_valid), 32'd1);
    check("s5_onehot", 32'(out_onehot), 32'h20);
    check("s5_last", 32'(out_last), 32'd1);
    check("s5_err", 32'(out_err), 32'd0);
    drain(0);

    // Back-to-back sweep: one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      issue(i, 0, 0, 0, w);
      check("sweep_nobubble", 32'(w), 32'd0);
      check("sweep_onehot", 32'(out_onehot), 32'(1 << i));
    end
    drain(0);

    // none / out-of-range on the N=6 instance.
    issue6(0, 1, 0);
    check("n6_none_oh", 32'(oh6), 32'd0);
    check("n6_none_flag", 32'({ovalid6, onone6, oerr6, olast6}), 32'b1101);
    issue6(7, 0, 1);
    check("n6_err_oh", 32'(oh6), 32'd0);
    check("n6_err_flag", 32'({ovalid6, onone6, oerr6, olast6}), 32'b1011);
    issue6(6, 0, 0);
    check("n6_err6_flag", 32'({ovalid6, oerr6, olast6}), 32'b111);
    issue6(5, 0, 1);
    check("n6_scan_top_oh", 32'(oh6), 32'h20);
    check("n6_scan_top_last", 32'(olast6), 32'd1);
    issue6(3, 0, 1);
    check("n6_scan3_b0", 32'({olast6, oh6}), 32'h008);
    @(posedge clk); #1;
    check("n6_scan3_b1", 32'({olast6, oh6}), 32'h010);
    @(posedge clk); #1;
    check("n6_scan3_b2", 32'({olast6, oh6}), 32'h060);
    @(posedge clk); #1;
    check("n6_idle", 32'({ovalid6, ready6}), 32'b01);

    // Scan with backpressure on the second beat.
    issue(5, 0, 1, 0, w);
    check("scan5_b0", 32'({out_last, out_onehot}), 32'h020);
    @(posedge clk); #1;
    check("scan5_b1", 32'({out_last, out_onehot}), 32'h040);
    out_ready = 1'b0;
    in_idx = 3'd2; in_scan = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_onehot", 32'(out_onehot), 32'h40);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("scan5_b2", 32'({out_last, out_onehot}), 32'h180);
    drain(0);

    // Scan starting at N-1, then a command with no bubble.
    issue(7, 0, 1, 0, w);
    check("scan7_beat", 32'({out_last, out_onehot}), 32'h180);
    issue(2, 0, 0, 0, w);
    check("scan7_followup_wait", 32'(w), 32'd0);
    check("scan7_followup_oh", 32'(out_onehot), 32'h04);
    drain(0);

    // Reset in the middle of a scan.
    issue(0, 0, 1, 0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_scan_b2", 32'(out_onehot), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_onehot", 32'(out_onehot), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", 32'(out_valid), 32'd0);
    issue(1, 0, 0, 0, w);
    check("postrst_onehot", 32'(out_onehot), 32'h02);
    drain(0);

    // Random commands with random backpressure.
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1, w);
    end
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Sequential binary-to-one-hot decoder: the inverse of the solver's one-hot encoder.
- Accepts a binary variable index plus a `none` flag over a valid/ready handshake and drives a registered one-hot select vector to the variable/clause arrays.
- Optional scan mode walks the one-hot select from a start index up to N-1, one beat per accepted output. This is used to iterate over the remaining unassigned variables.
- Round-trip property: encoder(decoder(i)) == i, with none=0.

Parameters:
- N, 8, number of one-hot outputs; legal range 2..1024.
- IW, log2c(N), index width; derived from `inc/math.v` log2c; not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_idx  in  IW  binary index to decode / scan start index
- in_none  in  1  "no selection"; single mode emits all-zero one-hot
- in_scan  in  1  0 = single decode, 1 = scan from in_idx to N-1
- in_valid  in  1  input command valid
- in_ready  out  1  block can accept a command
- out_onehot  out  N  registered one-hot select (all-zero when none/err)
- out_none  out  1  registered copy of in_none for this beat (matches encoder `none`)
- out_err  out  1  in_idx >= N (only possible when N is not a power of 2)
- out_last  out  1  final beat of a command (always 1 in single mode)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; out_onehot=0, out_none=0, out_err=0, out_last=0, out_valid=0, in_ready=1.
  - Deassertion is taken synchronously at the next clk edge.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - out_* are held stable while out_valid & ~out_ready.
  - No combinational path from in_valid to out_valid.
- Latency: 1 cycle from input transfer to out_valid.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). A back-to-back command is accepted in the same cycle the last beat leaves, giving full throughput in single mode.
- State machine IDLE / SINGLE / SCAN:
  - IDLE: on input transfer:
    - in_none=1, or in_idx>=N: go to SINGLE, out_onehot=0, out_last=1. Set out_err=(in_idx>=N) & ~in_none. Scan is ignored.
    - else in_scan=0: go to SINGLE, out_onehot = 1<<in_idx, out_last=1.
    - else in_scan=1: go to SCAN, cursor=in_idx, out_onehot=1<<in_idx, out_last=(in_idx==N-1).
  - SINGLE: on output transfer, go to IDLE, or reload directly if a new input transfers in the same cycle.
  - SCAN: on output transfer:
    - if out_last, behave as SINGLE (go IDLE / reload);
    - else cursor+1, out_onehot shifts left by 1, out_last=(cursor+1==N-1).
- Width/arithmetic:
  - The cursor is IW bits and never exceeds N-1, so there is no wrap-around.
  - Decode compare is against N, not 2**IW.
- Invariants:
  - out_onehot has popcount <= 1 at all times.
  - popcount==0 iff out_none|out_err.
- Reset mid-scan: aborts immediately to the reset values; no partial beat is re-emitted.
- in_valid while in_ready=0 is ignored; the upstream must hold it.

Decomposition:
- Shared package / `inc/math.v`: log2c (existing); state encoding localparams ST_IDLE=2'd0, ST_SINGLE=2'd1, ST_SCAN=2'd2.
- One natural sub-module: onehot_decode_comb (pure combinational, N, IW). It decodes index to one-hot with range check and emits the err flag. It is reused by the scan cursor path and the load path.

Test Plan:
- Reset: rst_n=0 mid-run, async, without a clk edge -> out_valid=0, out_onehot=0, in_ready=1 immediately.
- Single decode, N=8: idx=5, scan=0, out_ready=1 -> next cycle out_onehot=8'b0010_0000, out_last=1, out_err=0. Sweep 0..7 back-to-back -> one beat per cycle, and encoder(out_onehot)==idx.
- none/err, N=6: in_none=1 -> out_onehot=0, out_none=1. idx=7 -> out_onehot=0, out_err=1, out_last=1.
- Scan with backpressure, N=8:
  - idx=5, scan=1 -> beats 0x20, 0x40, 0x80 with out_last on 0x80 only.
  - out_ready held 0 for 3 cycles on beat 2 -> 0x40 stays stable and in_ready=0 throughout.
- Scan edge: idx=7, scan=1 -> single beat 0x80 with out_last=1. A new command presented on the same cycle is accepted without a bubble.
- Reset mid-scan: assert rst_n=0 during beat 2 of a scan from 0 -> outputs clear. After release, a new single idx=1 yields 0x02.
